// File: rtl/alt_vipcto121_pkg.sv
// Shared state encoding and default 1080p timing for the clocked video output.
package alt_vipcto121_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_FILL = 2'd1,
        RUN       = 2'd2
    } state_t;

    localparam int DEF_H_ACTIVE = 1920;
    localparam int DEF_H_FRONT  = 88;
    localparam int DEF_H_SYNC   = 44;
    localparam int DEF_H_BACK   = 148;
    localparam int DEF_V_ACTIVE = 1080;
    localparam int DEF_V_FRONT  = 4;
    localparam int DEF_V_SYNC   = 5;
    localparam int DEF_V_BACK   = 36;

endpackage

// File: rtl/alt_vipcto121_timing_gen.sv
// Raster position counters with active/sync/end-of-frame decode; counters idle at 0 unless run.
module alt_vipcto121_timing_gen
    import alt_vipcto121_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FRONT  = DEF_H_FRONT,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BACK   = DEF_H_BACK,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FRONT  = DEF_V_FRONT,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BACK   = DEF_V_BACK
) (
    input  logic clk,
    input  logic aclr_n,
    input  logic run,
    output logic active,
    output logic hsync,
    output logic vsync,
    output logic end_of_frame
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    // One spare bit so every region boundary is representable, even with zero back porch.
    localparam int HW = $clog2(H_TOTAL + 1);
    localparam int VW = $clog2(V_TOTAL + 1);

    logic [HW-1:0] h_p0;
    logic [VW-1:0] v_p0;
    logic          h_last;
    logic          v_last;

    assign h_last = (h_p0 == HW'(H_TOTAL - 1));
    assign v_last = (v_p0 == VW'(V_TOTAL - 1));

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            h_p0 <= '0;
            v_p0 <= '0;
        end else if (!run) begin
            h_p0 <= '0;
            v_p0 <= '0;
        end else if (h_last) begin
            h_p0 <= '0;
            v_p0 <= v_last ? '0 : v_p0 + VW'(1);
        end else begin
            h_p0 <= h_p0 + HW'(1);
        end
    end

    assign active       = run && (h_p0 < HW'(H_ACTIVE)) && (v_p0 < VW'(V_ACTIVE));
    assign hsync        = run && (h_p0 >= HW'(H_ACTIVE + H_FRONT))
                              && (h_p0 <  HW'(H_ACTIVE + H_FRONT + H_SYNC));
    assign vsync        = run && (v_p0 >= VW'(V_ACTIVE + V_FRONT))
                              && (v_p0 <  VW'(V_ACTIVE + V_FRONT + V_SYNC));
    assign end_of_frame = run && h_last && v_last;

endmodule

// File: rtl/alt_vipcto121_video_out.sv
// Clocked video output: drains a pixel FIFO into a raster with DE/HSYNC/VSYNC.
// Optional macro VIP_CVO_UNDERFLOW_COUNT_EN adds a saturating 16-bit starved-pixel counter.
module alt_vipcto121_video_out
    import alt_vipcto121_pkg::*;
#(
    parameter int DATA_WIDTH  = 20,
    parameter int FIFO_DEPTH  = 1920,
    parameter int H_ACTIVE    = DEF_H_ACTIVE,
    parameter int H_FRONT     = DEF_H_FRONT,
    parameter int H_SYNC      = DEF_H_SYNC,
    parameter int H_BACK      = DEF_H_BACK,
    parameter int V_ACTIVE    = DEF_V_ACTIVE,
    parameter int V_FRONT     = DEF_V_FRONT,
    parameter int V_SYNC      = DEF_V_SYNC,
    parameter int V_BACK      = DEF_V_BACK,
    parameter int START_LEVEL = 256,
    localparam int DATA_WIDTHU = $clog2(FIFO_DEPTH)
) (
    input  logic                   clk,
    input  logic                   aclr_n,
    input  logic                   enable,
    input  logic [DATA_WIDTH-1:0]  fifo_q,
    input  logic                   fifo_rdempty,
    input  logic [DATA_WIDTHU-1:0] fifo_rdusedw,
    output logic                   fifo_rdreq,
    output logic [DATA_WIDTH-1:0]  vid_data,
    output logic                   vid_de,
    output logic                   vid_hsync,
    output logic                   vid_vsync,
    output logic                   underflow
`ifdef VIP_CVO_UNDERFLOW_COUNT_EN
    ,
    output logic [15:0]            underflow_count
`endif
);

    state_t state;
    state_t state_nxt;
    logic   clr_und;
    logic   fill_ok;
    logic   run_p0;
    logic   active_p0;
    logic   hsync_p0;
    logic   vsync_p0;
    logic   eof_p0;
    logic   starve_p0;
    logic   de_p1;
    logic   hsync_p1;
    logic   vsync_p1;
    logic   vld_p1;
    logic   und_p1;

    // Widened by one bit so START_LEVEL equal to a power-of-two depth still compares correctly.
    assign fill_ok = ({1'b0, fifo_rdusedw} >= (DATA_WIDTHU + 1)'(START_LEVEL));
    assign run_p0  = (state == RUN);

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        clr_und   = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_nxt = WAIT_FILL;
                    clr_und   = 1'b1;
                end
            end
            WAIT_FILL: begin
                if (fill_ok) state_nxt = RUN;
            end
            RUN: begin
                if (eof_p0 && !enable) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    alt_vipcto121_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FRONT  (H_FRONT),
        .H_SYNC   (H_SYNC),
        .H_BACK   (H_BACK),
        .V_ACTIVE (V_ACTIVE),
        .V_FRONT  (V_FRONT),
        .V_SYNC   (V_SYNC),
        .V_BACK   (V_BACK)
    ) u_timing (
        .clk          (clk),
        .aclr_n       (aclr_n),
        .run          (run_p0),
        .active       (active_p0),
        .hsync        (hsync_p0),
        .vsync        (vsync_p0),
        .end_of_frame (eof_p0)
    );

    assign fifo_rdreq = active_p0 && !fifo_rdempty;
    assign starve_p0  = active_p0 && fifo_rdempty;

    // Stage 1: pins. The FIFO's own output register supplies the data word in this cycle,
    // so data is gated by the registered read-valid rather than re-registered.
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            de_p1    <= 1'b0;
            hsync_p1 <= 1'b0;
            vsync_p1 <= 1'b0;
            vld_p1   <= 1'b0;
            und_p1   <= 1'b0;
        end else begin
            de_p1    <= active_p0;
            hsync_p1 <= hsync_p0;
            vsync_p1 <= vsync_p0;
            vld_p1   <= fifo_rdreq;
            if (clr_und)        und_p1 <= 1'b0;
            else if (starve_p0) und_p1 <= 1'b1;
        end
    end

    assign vid_data  = vld_p1 ? fifo_q : '0;
    assign vid_de    = de_p1;
    assign vid_hsync = hsync_p1;
    assign vid_vsync = vsync_p1;
    assign underflow = und_p1;

`ifdef VIP_CVO_UNDERFLOW_COUNT_EN
    logic [15:0] und_cnt_p1;

    function automatic logic [15:0] sat_inc16(input logic [15:0] val);
        return (val == 16'hFFFF) ? val : val + 16'd1;
    endfunction

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n)        und_cnt_p1 <= '0;
        else if (clr_und)   und_cnt_p1 <= '0;
        else if (starve_p0) und_cnt_p1 <= sat_inc16(und_cnt_p1);
    end

    assign underflow_count = und_cnt_p1;
`endif

endmodule

// File: tb/tb_alt_vipcto121_video_out.sv
// Self-checking bench: small raster, in-bench FIFO model and a position-based reference model.
module tb_alt_vipcto121_video_out;

    localparam int DW = 8;
    localparam int HA = 4, HF = 1, HS = 1, HB = 2;
    localparam int VA = 2, VF = 1, VS = 1, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;

    logic          clk = 1'b0;
    logic          aclr_n;
    logic          enable;
    logic [DW-1:0] fifo_q;
    logic          fifo_rdempty;
    logic [4:0]    fifo_rdusedw;
    logic          fifo_rdreq;
    logic [DW-1:0] vid_data;
    logic          vid_de;
    logic          vid_hsync;
    logic          vid_vsync;
    logic          underflow;
`ifdef VIP_CVO_UNDERFLOW_COUNT_EN
    logic [15:0]   underflow_count;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    bit und_exp  = 1'b0;
    int cnt_exp  = 0;

    // FIFO model: non-show-ahead, data appears the clock after the read strobe
    logic [DW-1:0] mem [0:255];
    logic [DW-1:0] exp_q [$];
    int  wr_ptr = 0;
    int  rd_ptr = 0;
    bit  force_empty = 1'b0;

    assign fifo_rdempty = force_empty || (wr_ptr == rd_ptr);
    assign fifo_rdusedw = 5'(wr_ptr - rd_ptr);

    always @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            rd_ptr <= wr_ptr;
            fifo_q <= '0;
        end else if (fifo_rdreq) begin
            fifo_q <= mem[rd_ptr];
            rd_ptr <= rd_ptr + 1;
        end
    end

    always #5 clk = ~clk;

    alt_vipcto121_video_out #(
        .DATA_WIDTH (DW), .FIFO_DEPTH (32),
        .H_ACTIVE (HA), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
        .V_ACTIVE (VA), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB),
        .START_LEVEL (4)
    ) dut (
        .clk (clk), .aclr_n (aclr_n), .enable (enable),
        .fifo_q (fifo_q), .fifo_rdempty (fifo_rdempty), .fifo_rdusedw (fifo_rdusedw),
        .fifo_rdreq (fifo_rdreq), .vid_data (vid_data), .vid_de (vid_de),
        .vid_hsync (vid_hsync), .vid_vsync (vid_vsync), .underflow (underflow)
`ifdef VIP_CVO_UNDERFLOW_COUNT_EN
        , .underflow_count (underflow_count)
`endif
    );

    task automatic push(input int n);
        logic [DW-1:0] v;
        for (int i = 0; i < n; i++) begin
            v = DW'($urandom_range(1, 255));
            mem[wr_ptr] = v;
            exp_q.push_back(v);
            wr_ptr++;
        end
    endtask

    // Walks output cycles k (k=0 is the first pixel at the pins) comparing against the raster
    // implied by position k within the frame; starve[k] marks pixels whose FIFO read is refused.
    task automatic check_run(input int start_k, input int frames, input int drop_k,
                             input logic [127:0] starve, input int tail, input int force_k);
        int total, p, n;
        logic e_de, e_hs, e_vs, e_rd;
        logic [DW-1:0] e_dat;
        total = frames * FT;
        for (int k = start_k; k < total + tail; k++) begin
            @(negedge clk);
            e_de = 0; e_hs = 0; e_vs = 0; e_dat = '0;
            if (k >= 0 && k < total) begin
                p    = k % FT;
                e_de = ((p % HT) < HA) && ((p / HT) < VA);
                e_hs = ((p % HT) >= HA + HF) && ((p % HT) < HA + HF + HS);
                e_vs = ((p / HT) >= VA + VF) && ((p / HT) < VA + VF + VS);
                if (e_de) begin
                    if (starve[k]) begin
                        und_exp = 1'b1;
                        if (cnt_exp < 65535) cnt_exp++;
                    end else begin
                        e_dat = exp_q.pop_front();
                    end
                end
            end
            n_checks++;
            if (vid_de !== e_de) $display("FAIL vid_de k=%0d got %b want %b", k, vid_de, e_de);
            else n_pass++;
            n_checks++;
            if (vid_hsync !== e_hs) $display("FAIL vid_hsync k=%0d got %b want %b", k, vid_hsync, e_hs);
            else n_pass++;
            n_checks++;
            if (vid_vsync !== e_vs) $display("FAIL vid_vsync k=%0d got %b want %b", k, vid_vsync, e_vs);
            else n_pass++;
            n_checks++;
            if (vid_data !== e_dat) $display("FAIL vid_data k=%0d got %h want %h", k, vid_data, e_dat);
            else n_pass++;
            n_checks++;
            if (underflow !== und_exp) $display("FAIL underflow k=%0d got %b want %b", k, underflow, und_exp);
            else n_pass++;
`ifdef VIP_CVO_UNDERFLOW_COUNT_EN
            n_checks++;
            if (underflow_count !== 16'(cnt_exp))
                $display("FAIL underflow_count k=%0d got %0d want %0d", k, underflow_count, cnt_exp);
            else n_pass++;
            if (k == force_k) begin
                force dut.und_cnt_p1 = 16'hFFFE;
                release dut.und_cnt_p1;
                cnt_exp = 65534;
            end
`endif
            if (k == drop_k) enable = 1'b0;
            n = k + 1;
            e_rd = 1'b0;
            force_empty = 1'b0;
            if (n >= 0 && n < total) begin
                p    = n % FT;
                e_rd = ((p % HT) < HA) && ((p / HT) < VA) && !starve[n];
                force_empty = starve[n];
            end
            #1;
            n_checks++;
            if (fifo_rdreq !== e_rd) $display("FAIL fifo_rdreq k=%0d got %b want %b", n, fifo_rdreq, e_rd);
            else n_pass++;
        end
        force_empty = 1'b0;
    endtask

    task automatic test_reset();
        aclr_n = 1'b0;
        enable = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({vid_de, vid_hsync, vid_vsync, fifo_rdreq, underflow} !== 5'b0)
            $display("FAIL reset_ctrl got %b want 00000", {vid_de, vid_hsync, vid_vsync, fifo_rdreq, underflow});
        else n_pass++;
        n_checks++;
        if (vid_data !== '0) $display("FAIL reset_data got %h want 00", vid_data);
        else n_pass++;
        aclr_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({vid_de, fifo_rdreq} !== 2'b0) $display("FAIL idle_after_reset got %b want 00", {vid_de, fifo_rdreq});
        else n_pass++;
    endtask

    task automatic test_fill_wait();
        enable = 1'b1;
        push(3);
        repeat (4) begin
            @(negedge clk);
            #1;
            n_checks++;
            if ({vid_de, fifo_rdreq} !== 2'b0) $display("FAIL fill_wait got %b want 00", {vid_de, fifo_rdreq});
            else n_pass++;
        end
        push(1);
        @(negedge clk);
        #1;
        n_checks++;
        if ({vid_de, fifo_rdreq} !== 2'b01) $display("FAIL run_start got %b want 01", {vid_de, fifo_rdreq});
        else n_pass++;
        push(12);
    endtask

    task automatic test_back_to_back();
        check_run(0, 2, FT + 2, 128'h0, 6, -1);
    endtask

    task automatic test_underflow();
        und_exp = 1'b0;
        cnt_exp = 0;
        enable  = 1'b1;
        repeat (2) @(negedge clk);
        push(7);
        check_run(-1, 1, 0, 128'h4, 4, -1);
    endtask

    task automatic test_reset_mid_line();
        enable = 1'b1;
        und_exp = 1'b0;
        cnt_exp = 0;
        @(negedge clk);
        n_checks++;
        if (underflow !== 1'b0) $display("FAIL underflow_clear_on_enable got %b want 0", underflow);
        else n_pass++;
        @(negedge clk);
        push(8);
        repeat (4) @(negedge clk);
        n_checks++;
        if (vid_de !== 1'b1) $display("FAIL pre_reset_de got %b want 1", vid_de);
        else n_pass++;
        aclr_n = 1'b0;
        #1;
        n_checks++;
        if ({vid_de, vid_hsync, vid_vsync, fifo_rdreq, underflow} !== 5'b0 || vid_data !== '0)
            $display("FAIL mid_line_reset got %b/%h want 00000/00",
                     {vid_de, vid_hsync, vid_vsync, fifo_rdreq, underflow}, vid_data);
        else n_pass++;
        exp_q.delete();
        @(negedge clk);
        aclr_n = 1'b1;
        push(3);
        repeat (4) begin
            @(negedge clk);
            #1;
            n_checks++;
            if ({vid_de, fifo_rdreq} !== 2'b0) $display("FAIL refill_wait got %b want 00", {vid_de, fifo_rdreq});
            else n_pass++;
        end
        push(5);
        check_run(-1, 1, 0, 128'h0, 3, -1);
    endtask

    task automatic test_underflow_count();
        logic [127:0] m;
        m = '0;
        m[1] = 1'b1; m[9] = 1'b1; m[10] = 1'b1;
        m[FT + 1] = 1'b1; m[FT + 2] = 1'b1; m[FT + 3] = 1'b1;
        und_exp = 1'b0;
        cnt_exp = 0;
        enable  = 1'b1;
        repeat (2) @(negedge clk);
        push(10);
        check_run(-1, 2, FT + 2, m, 3, FT - 1);
    endtask

    initial begin
        aclr_n = 1'b0;
        enable = 1'b0;
        test_reset();
        test_fill_wait();
        test_back_to_back();
        test_underflow();
        test_reset_mid_line();
`ifdef VIP_CVO_UNDERFLOW_COUNT_EN
        test_underflow_count();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
